// File: rtl/alu_pkg.sv
// Shared ALU definitions: the default datapath width, the serial digit size and the
// state encoding used by the multi-cycle subtractor.
package alu_pkg;

  localparam int ALU_WIDTH = 18;
  localparam int SUB_DIGIT = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_digit.sv
// digit_subtractor: DIGIT-bit combinational ripple of full-subtractor cells.
// A single instance is reused by the serial subtractor on every RUN cycle.
module digit_subtractor
  import alu_pkg::*;
#(
  parameter int DIGIT = SUB_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] chain;

  assign chain[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]         = a[i] ^ b[i] ^ chain[i];
    assign chain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
  end

  assign bout = chain[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor Output = SRC1 - SRC2, DIGIT bits per cycle, LSB first, with a
// start/done handshake. Optional signed-overflow port ovf when SUB_OVF_FLAG_EN is defined.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DIGIT = SUB_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] SRC1,
  input  logic [WIDTH-1:0] SRC2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Output,
  output logic             borrow,
  output logic             zero
`ifdef SUB_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // The accumulator below holds NDIG-1 finished digits, so at least two digits are needed.
  if ((WIDTH % DIGIT) != 0 || NDIG < 2) begin : g_bad_config
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT with at least two digits");
  end

  logic [1:0]             state;
  logic [WIDTH-1:0]       opa;
  logic [WIDTH-1:0]       opb;
  logic [WIDTH-DIGIT-1:0] acc;
  logic                   borrow_r;
  logic [CW-1:0]          cnt;
  logic [DIGIT-1:0]       dg;
  logic                   bout;
  logic [WIDTH-1:0]       full;
`ifdef SUB_OVF_FLAG_EN
  logic                   sign_a;
  logic                   sign_b;
`endif

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .a   (opa[DIGIT-1:0]),
    .b   (opb[DIGIT-1:0]),
    .bin (borrow_r),
    .d   (dg),
    .bout(bout)
  );

  // New digits enter at the top, so after the last digit the word is already in place.
  assign full = {dg, acc};
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
      Output   <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            opa      <= SRC1;
            opb      <= SRC2;
            borrow_r <= 1'b0;
            cnt      <= '0;
            state    <= ST_RUN;
`ifdef SUB_OVF_FLAG_EN
            sign_a   <= SRC1[WIDTH-1];
            sign_b   <= SRC2[WIDTH-1];
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          opa      <= opa >> DIGIT;
          opb      <= opb >> DIGIT;
          acc      <= full[WIDTH-1:DIGIT];
          borrow_r <= bout;
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(NDIG - 1)) begin
            state  <= ST_DONE;
            Output <= full;
            borrow <= bout;
            zero   <= (full == '0);
`ifdef SUB_OVF_FLAG_EN
            ovf    <= (sign_a != sign_b) && (full[WIDTH-1] != sign_a);
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table plus random operands through a
// scoreboard, and hand-written sequences for start-during-RUN, back-to-back and reset cases.
module tb_serial_subtractor;
  import alu_pkg::*;

  localparam int W    = ALU_WIDTH;
  localparam int NDIG = ALU_WIDTH / SUB_DIGIT;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] SRC1;
  logic [W-1:0] SRC2;
  logic         busy;
  logic         done;
  logic [W-1:0] Output;
  logic         borrow;
  logic         zero;
`ifdef SUB_OVF_FLAG_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_subtractor dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .SRC1  (SRC1),
    .SRC2  (SRC2),
    .busy  (busy),
    .done  (done),
    .Output(Output),
    .borrow(borrow),
    .zero  (zero)
`ifdef SUB_OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         brw;
    logic         zr;
    logic         ov;
  } vec_t;

  vec_t         sb[$];
  vec_t         vecs[8];
  int           checks  = 0;
  int           errors  = 0;
  logic [W-1:0] lastOut = '0;

  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    v.a   = a;
    v.b   = b;
    v.out = a - b;
    v.brw = (a < b);
    v.zr  = (v.out == '0);
    v.ov  = (a[W-1] != b[W-1]) && (v.out[W-1] != a[W-1]);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one start cycle; returns at the falling edge of the first RUN cycle.
  task automatic applyStimulus(input vec_t v, input bit track);
    @(negedge clk);
    SRC1  = v.a;
    SRC2  = v.b;
    start = 1'b1;
    if (track) sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    SRC1  = W'($urandom);
    SRC2  = W'($urandom);
  endtask

  task automatic collectResult(input int already);
    vec_t e;
    int   cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!done) checkOutput("out_stable_run", Output, lastOut);
    end while (!done && cycles < 20);
    checkOutput("latency", cycles, NDIG - already);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("output", Output, e.out);
      checkOutput("borrow", borrow, e.brw);
      checkOutput("zero", zero, e.zr);
`ifdef SUB_OVF_FLAG_EN
      checkOutput("ovf", ovf, e.ov);
`endif
      lastOut = e.out;
    end else begin
      checkOutput("scoreboard_empty", 1, 0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   sawDone;
    vec_t v;

    vecs[0] = '{a: 18'd100,    b: 18'd30,     out: 18'd70,     brw: 1'b0, zr: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 18'd5,      b: 18'd7,      out: 18'h3FFFE,  brw: 1'b1, zr: 1'b0, ov: 1'b0};
    vecs[2] = '{a: 18'h2AAAA,  b: 18'h2AAAA,  out: 18'h00000,  brw: 1'b0, zr: 1'b1, ov: 1'b0};
    vecs[3] = '{a: 18'h20000,  b: 18'd1,      out: 18'h1FFFF,  brw: 1'b0, zr: 1'b0, ov: 1'b1};
    vecs[4] = '{a: 18'd3,      b: 18'd1,      out: 18'd2,      brw: 1'b0, zr: 1'b0, ov: 1'b0};
    vecs[5] = '{a: 18'd0,      b: 18'd1,      out: 18'h3FFFF,  brw: 1'b1, zr: 1'b0, ov: 1'b0};
    vecs[6] = '{a: 18'h3FFFF,  b: 18'd0,      out: 18'h3FFFF,  brw: 1'b0, zr: 1'b0, ov: 1'b0};
    vecs[7] = '{a: 18'h1FFFF,  b: 18'h3FFFF,  out: 18'h20000,  brw: 1'b1, zr: 1'b0, ov: 1'b1};

    reset = 1'b1;
    start = 1'b0;
    SRC1  = '0;
    SRC2  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_output", Output, 0);
    checkOutput("reset_borrow", borrow, 0);
    checkOutput("reset_zero", zero, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
`ifdef SUB_OVF_FLAG_EN
    checkOutput("reset_ovf", ovf, 0);
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], 1'b1);
      checkOutput("busy_run", busy, 1);
      collectResult(0);
      @(negedge clk);
      checkOutput("done_pulse", done, 0);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(model(W'($urandom), W'($urandom)), 1'b1);
      collectResult(0);
    end

    // A start raised in RUN cycle 3 must be ignored; a start held during DONE chains on.
    applyStimulus(vecs[0], 1'b1);
    repeat (2) @(negedge clk);
    SRC1  = 18'd999;
    SRC2  = 18'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collectResult(3);
    v     = model(18'h12345, 18'h00F0F);
    SRC1  = v.a;
    SRC2  = v.b;
    start = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_busy", busy, 1);
    collectResult(0);

    // Reset in RUN cycle 4 aborts with no done pulse and clears the results.
    applyStimulus(vecs[1], 1'b1);
    collectResult(0);
    applyStimulus(vecs[0], 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    lastOut = '0;
    checkOutput("abort_output", Output, 0);
    checkOutput("abort_borrow", borrow, 0);
    checkOutput("abort_zero", zero, 0);
    checkOutput("abort_busy", busy, 0);
    sawDone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) sawDone++;
    end
    checkOutput("abort_no_done", sawDone, 0);

    // Reset wins over a simultaneous start.
    SRC1  = 18'd10;
    SRC2  = 18'd3;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("reset_vs_start_busy", busy, 0);
    @(negedge clk);
    checkOutput("reset_vs_start_idle", busy, 0);
    checkOutput("reset_vs_start_output", Output, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
